// File: rtl/bram_block_dp_pipelined.sv
`timescale 1ns/1ps
// Single-clock dual-port block RAM: configurable width, depth, read latency and
// per-port write mode; same-word collisions resolve with port A priority and are counted.
module bram_block_dp_pipelined #(
  parameter int unsigned C_MEMSIZE      = 'h4000,
  parameter int unsigned C_PORT_DWIDTH  = 32,
  parameter int unsigned C_PORT_AWIDTH  = 32,
  parameter int unsigned C_NUM_WE       = 4,
  parameter int unsigned C_READ_LATENCY = 1,
  parameter string       C_WMODE_A      = "READ_FIRST",
  parameter string       C_WMODE_B      = "READ_FIRST"
) (
  input  logic                       BRAM_Clk,
  input  logic                       BRAM_Rst,
  input  logic                       BRAM_EN_A,
  input  logic [0:C_NUM_WE-1]        BRAM_WEN_A,
  input  logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_A,
  input  logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_A,
  output logic [0:C_PORT_DWIDTH-1]   BRAM_Din_A,
  input  logic                       BRAM_EN_B,
  input  logic [0:C_NUM_WE-1]        BRAM_WEN_B,
  input  logic [0:C_PORT_AWIDTH-1]   BRAM_Addr_B,
  input  logic [0:C_PORT_DWIDTH-1]   BRAM_Dout_B,
  output logic [0:C_PORT_DWIDTH-1]   BRAM_Din_B,
  output logic [15:0]                Collision_Cnt
);

  localparam int unsigned DW    = C_PORT_DWIDTH;
  localparam int unsigned NWE   = C_NUM_WE;
  localparam int unsigned DEPTH = C_MEMSIZE / C_NUM_WE;
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OFF   = (NWE > 1) ? $clog2(NWE) : 0;

  localparam logic [1:0] WM_RF = 2'd0;
  localparam logic [1:0] WM_WF = 2'd1;
  localparam logic [1:0] WM_NC = 2'd2;
  localparam logic [1:0] MODE_A = (C_WMODE_A == "WRITE_FIRST") ? WM_WF :
                                  (C_WMODE_A == "NO_CHANGE")   ? WM_NC : WM_RF;
  localparam logic [1:0] MODE_B = (C_WMODE_B == "WRITE_FIRST") ? WM_WF :
                                  (C_WMODE_B == "NO_CHANGE")   ? WM_NC : WM_RF;

  // Elaboration-time parameter legality checks
  if (NWE * 8 != DW || !(DW == 32 || DW == 64)) begin : g_bad_width
    $error("bram_block_dp_pipelined: C_PORT_DWIDTH must be 32/64 and equal 8*C_NUM_WE");
  end
  if (C_MEMSIZE < NWE * 2 || (C_MEMSIZE & (C_MEMSIZE - 1)) != 0) begin : g_bad_size
    $error("bram_block_dp_pipelined: C_MEMSIZE must be a power of 2 and >= 2*C_NUM_WE");
  end
  if (OFF + IW > C_PORT_AWIDTH) begin : g_bad_awidth
    $error("bram_block_dp_pipelined: C_PORT_AWIDTH too narrow for C_MEMSIZE");
  end
  if (C_READ_LATENCY < 1 || C_READ_LATENCY > 2) begin : g_bad_lat
    $error("bram_block_dp_pipelined: C_READ_LATENCY must be 1 or 2");
  end
  if (C_WMODE_A != "READ_FIRST" && C_WMODE_A != "WRITE_FIRST" && C_WMODE_A != "NO_CHANGE") begin : g_bad_mode_a
    $error("bram_block_dp_pipelined: unknown C_WMODE_A");
  end
  if (C_WMODE_B != "READ_FIRST" && C_WMODE_B != "WRITE_FIRST" && C_WMODE_B != "NO_CHANGE") begin : g_bad_mode_b
    $error("bram_block_dp_pipelined: unknown C_WMODE_B");
  end

  // Big-endian port vectors land in descending internals: wen bit k covers data [8k +: 8]
  logic [NWE-1:0]           wen_a, wen_b;
  logic [C_PORT_AWIDTH-1:0] addr_a, addr_b;
  logic [DW-1:0]            wdata_a, wdata_b;
  logic [IW-1:0]            idx_a, idx_b;
  logic                     unused_addr;

  assign wen_a   = BRAM_WEN_A;
  assign wen_b   = BRAM_WEN_B;
  assign addr_a  = BRAM_Addr_A;
  assign addr_b  = BRAM_Addr_B;
  assign wdata_a = BRAM_Dout_A;
  assign wdata_b = BRAM_Dout_B;
  assign idx_a   = addr_a[OFF +: IW];
  assign idx_b   = addr_b[OFF +: IW];
  assign unused_addr = ^{addr_a, addr_b};

  logic [DW-1:0] mem [DEPTH];

  logic [NWE-1:0] we_a, we_b;
  logic           coll, overlap;
  logic [DW-1:0]  old_a, old_b, new_a, new_b;
  logic [DW-1:0]  rd_a, rd_b;
  logic           upd_a, upd_b;

  // Final merged words: on a collision both ports see the same word, A winning shared lanes
  always_comb begin
    we_a    = (BRAM_EN_A && !BRAM_Rst) ? wen_a : '0;
    we_b    = (BRAM_EN_B && !BRAM_Rst) ? wen_b : '0;
    old_a   = mem[idx_a];
    old_b   = mem[idx_b];
    coll    = BRAM_EN_A && BRAM_EN_B && !BRAM_Rst && (idx_a == idx_b) && ((|we_a) || (|we_b));
    overlap = coll && (|(we_a & we_b));
    new_a   = old_a;
    new_b   = old_b;
    for (int k = 0; k < int'(NWE); k++) begin
      if (we_a[k])               new_a[8*k +: 8] = wdata_a[8*k +: 8];
      else if (coll && we_b[k])  new_a[8*k +: 8] = wdata_b[8*k +: 8];
      if (coll && we_a[k])       new_b[8*k +: 8] = wdata_a[8*k +: 8];
      else if (we_b[k])          new_b[8*k +: 8] = wdata_b[8*k +: 8];
    end
  end

  // Read-data selection per write mode; a losing B port falls back to the old word
  always_comb begin
    rd_a  = old_a;
    upd_a = BRAM_EN_A;
    rd_b  = old_b;
    upd_b = BRAM_EN_B;
    if (|we_a) begin
      case (MODE_A)
        WM_WF:   rd_a  = new_a;
        WM_NC:   upd_a = 1'b0;
        default: rd_a  = old_a;
      endcase
    end
    if ((|we_b) && !overlap) begin
      case (MODE_B)
        WM_WF:   rd_b  = new_b;
        WM_NC:   upd_b = 1'b0;
        default: rd_b  = old_b;
      endcase
    end
  end

  always_ff @(posedge BRAM_Clk) begin
    if (|we_a) mem[idx_a] <= new_a;
    if (|we_b) mem[idx_b] <= new_b;
  end

  logic [DW-1:0] s1_a, s1_b;
  logic          v1_a, v1_b;

  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      s1_a          <= '0;
      s1_b          <= '0;
      v1_a          <= 1'b0;
      v1_b          <= 1'b0;
      Collision_Cnt <= '0;
    end else begin
      v1_a <= BRAM_EN_A;
      v1_b <= BRAM_EN_B;
      if (upd_a) s1_a <= rd_a;
      if (upd_b) s1_b <= rd_b;
      if (coll && Collision_Cnt != 16'hFFFF) Collision_Cnt <= Collision_Cnt + 16'd1;
    end
  end

  if (C_READ_LATENCY == 2) begin : g_lat2
    logic [DW-1:0] s2_a, s2_b;
    always_ff @(posedge BRAM_Clk) begin
      if (BRAM_Rst) begin
        s2_a <= '0;
        s2_b <= '0;
      end else begin
        if (v1_a) s2_a <= s1_a;
        if (v1_b) s2_b <= s1_b;
      end
    end
    assign BRAM_Din_A = s2_a;
    assign BRAM_Din_B = s2_b;
  end else begin : g_lat1
    logic unused_valid;
    assign unused_valid = v1_a ^ v1_b;
    assign BRAM_Din_A = s1_a;
    assign BRAM_Din_B = s1_b;
  end

endmodule

// File: tb/tb_bram_block_dp_pipelined.sv
`timescale 1ns/1ps
// Scoreboard bench: two instances (latency 1 / READ_FIRST, latency 2 / WRITE_FIRST-A NO_CHANGE-B)
// share stimulus; expected outputs are queued with their due cycle and checked by a monitor.
module tb_bram_block_dp_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [0:3]  wen_a, wen_b;
  logic [0:31] addr_a, addr_b, wd_a, wd_b;
  logic [0:31] din_a0, din_b0, din_a1, din_b1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  bram_block_dp_pipelined u_dut0 (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(wd_a), .BRAM_Din_A(din_a0),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(wd_b), .BRAM_Din_B(din_b0),
    .Collision_Cnt(cnt0)
  );

  bram_block_dp_pipelined #(
    .C_READ_LATENCY(2), .C_WMODE_A("WRITE_FIRST"), .C_WMODE_B("NO_CHANGE")
  ) u_dut1 (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .BRAM_EN_A(en_a), .BRAM_WEN_A(wen_a), .BRAM_Addr_A(addr_a), .BRAM_Dout_A(wd_a), .BRAM_Din_A(din_a1),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b), .BRAM_Dout_B(wd_b), .BRAM_Din_B(din_b1),
    .Collision_Cnt(cnt1)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return din_a0;
      1:       return din_b0;
      2:       return din_a1;
      3:       return din_b1;
      4:       return {16'h0, cnt0};
      default: return {16'h0, cnt1};
    endcase
  endfunction

  // Monitor: compare every queued expectation in the cycle it falls due
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        n_vec++;
        if (sb[i].due != cyc || actual(sb[i].sel) !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s (sel %0d, cycle %0d): got %h expected %h",
                   sb[i].name, sb[i].sel, cyc, actual(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  // sel 0/1 = dut0 A/B, 2/3 = dut1 A/B, 4/5 = dut0/dut1 counter; lat = edges until due
  task automatic push(input int sel, input int lat, input logic [31:0] v, input string nm);
    sb_t e;
    e.due  = cyc + lat;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic set_a(input logic en, input logic [0:3] wen, input logic [31:0] addr, input logic [31:0] d);
    en_a = en; wen_a = wen; addr_a = addr; wd_a = d;
  endtask

  task automatic set_b(input logic en, input logic [0:3] wen, input logic [31:0] addr, input logic [31:0] d);
    en_b = en; wen_b = wen; addr_b = addr; wd_b = d;
  endtask

  task automatic idle();
    set_a(1'b0, 4'h0, 32'h0, 32'h0);
    set_b(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    for (int s = 0; s < 6; s++) push(s, 1, 32'h0, "init_reset");
    tick();

    // Reset with preloaded word; writes during reset must be ignored and not counted
    rst = 1'b0;
    set_a(1'b1, 4'hF, 32'h0, 32'hDEADBEEF);
    tick();
    rst = 1'b1;
    set_a(1'b1, 4'hF, 32'h0, 32'h0);
    set_b(1'b1, 4'hF, 32'h0, 32'h0);
    for (int s = 0; s < 6; s++) push(s, 1, 32'h0, "reset_clear");
    tick();
    rst = 1'b0;
    set_a(1'b1, 4'h0, 32'h0, 32'h0);
    set_b(1'b1, 4'h0, 32'h2, 32'h0);
    push(0, 1, 32'hDEADBEEF, "rd0_a_l1");
    push(1, 1, 32'hDEADBEEF, "rd0_b_l1");
    push(2, 2, 32'hDEADBEEF, "rd0_a_l2");
    push(3, 2, 32'hDEADBEEF, "rd0_b_l2");
    push(4, 1, 32'h0, "cnt_both_read");
    tick();
    idle();
    push(0, 1, 32'hDEADBEEF, "hold_a_l1");
    push(3, 2, 32'hDEADBEEF, "hold_b_l2");
    tick();

    // Byte-lane write, big-endian enables
    set_a(1'b1, 4'hF, 32'h10, 32'h0);
    push(2, 2, 32'h0, "wf_init10");
    tick();
    set_a(1'b1, 4'b1010, 32'h10, 32'h11223344);
    push(0, 1, 32'h0, "rf_old10");
    push(2, 2, 32'h11003300, "wf_merge10");
    tick();
    set_a(1'b1, 4'h0, 32'h0, 32'h0);
    push(0, 1, 32'hDEADBEEF, "rd0_again_l1");
    push(2, 2, 32'hDEADBEEF, "rd0_again_l2");
    tick();
    set_a(1'b1, 4'h0, 32'h10, 32'h0);
    push(0, 1, 32'h11003300, "rd10_l1");
    push(2, 1, 32'hDEADBEEF, "lat2_pending");
    push(2, 2, 32'h11003300, "rd10_l2");
    tick();

    // Write modes
    set_a(1'b1, 4'hF, 32'h30, 32'hAAAAAAAA);
    set_b(1'b1, 4'hF, 32'h34, 32'h77777777);
    push(2, 2, 32'hAAAAAAAA, "wf_init30");
    push(3, 2, 32'hDEADBEEF, "nc_b_first");
    tick();
    set_a(1'b1, 4'hF, 32'h30, 32'h55555555);
    set_b(1'b1, 4'h0, 32'h34, 32'h0);
    push(0, 1, 32'hAAAAAAAA, "mode_read_first");
    push(2, 2, 32'h55555555, "mode_write_first");
    push(1, 1, 32'h77777777, "rd34_l1");
    push(3, 2, 32'h77777777, "rd34_l2");
    tick();
    set_a(1'b0, 4'h0, 32'h0, 32'h0);
    set_b(1'b1, 4'hF, 32'h34, 32'h12345678);
    push(1, 1, 32'h77777777, "b_read_first");
    push(3, 2, 32'h77777777, "b_no_change");
    tick();
    set_b(1'b1, 4'h0, 32'h34, 32'h0);
    push(1, 1, 32'h12345678, "rd34_new_l1");
    push(3, 2, 32'h12345678, "rd34_new_l2");
    tick();

    // Dual-write collision: A wins shared lane
    set_a(1'b1, 4'hF, 32'h20, 32'h0);
    set_b(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    set_a(1'b1, 4'b1100, 32'h20, 32'h11111111);
    set_b(1'b1, 4'b0110, 32'h20, 32'h22222222);
    push(0, 1, 32'h0, "coll_a_rf");
    push(2, 2, 32'h11112200, "coll_a_wf");
    push(4, 1, 32'd1, "cnt_ww_l1");
    push(5, 1, 32'd1, "cnt_ww_l2");
    tick();
    set_a(1'b1, 4'h0, 32'h20, 32'h0);
    set_b(1'b0, 4'h0, 32'h0, 32'h0);
    push(0, 1, 32'h11112200, "coll_word_l1");
    push(2, 2, 32'h11112200, "coll_word_l2");
    tick();

    // Read/write collision, sub-word address bits ignored
    set_a(1'b1, 4'hF, 32'h40, 32'h0);
    tick();
    set_a(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
    set_b(1'b1, 4'h0, 32'h43, 32'h0);
    push(1, 1, 32'h0, "rw_coll_b_l1");
    push(3, 2, 32'h0, "rw_coll_b_l2");
    push(2, 2, 32'hCAFEF00D, "rw_coll_a_wf");
    push(4, 1, 32'd2, "cnt_rw_l1");
    push(5, 1, 32'd2, "cnt_rw_l2");
    tick();
    set_a(1'b1, 4'h0, 32'h40, 32'h0);
    set_b(1'b1, 4'h0, 32'h41, 32'h0);
    push(1, 1, 32'hCAFEF00D, "rd40_b_l1");
    push(3, 2, 32'hCAFEF00D, "rd40_b_l2");
    push(4, 1, 32'd2, "cnt_rr_l1");
    push(5, 1, 32'd2, "cnt_rr_l2");
    tick();

    // Address wrap: C_MEMSIZE + 8 aliases word 2
    set_a(1'b1, 4'hF, 32'h4008, 32'h0BADF00D);
    set_b(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    set_a(1'b0, 4'h0, 32'h0, 32'h0);
    set_b(1'b1, 4'h0, 32'h8, 32'h0);
    push(1, 1, 32'h0BADF00D, "wrap_l1");
    push(3, 2, 32'h0BADF00D, "wrap_l2");
    tick();

    // Saturation burst, then reset in the middle of it
    for (int i = 0; i < 65540; i++) begin
      set_a(1'b1, 4'hF, 32'h50, 32'(i));
      set_b(1'b1, 4'hF, 32'h50, ~32'(i));
      if (i == 65539) begin
        push(4, 1, 32'hFFFF, "cnt_sat_l1");
        push(5, 1, 32'hFFFF, "cnt_sat_l2");
      end
      tick();
    end
    rst = 1'b1;
    set_a(1'b1, 4'hF, 32'h50, 32'hFFFFFFFF);
    set_b(1'b1, 4'hF, 32'h50, 32'hFFFFFFFF);
    for (int s = 0; s < 6; s++) push(s, 1, 32'h0, "midburst_reset");
    tick();
    rst = 1'b0;
    set_a(1'b1, 4'h0, 32'h50, 32'h0);
    set_b(1'b0, 4'h0, 32'h0, 32'h0);
    push(0, 1, 32'h00010003, "no_write_in_reset_l1");
    push(2, 2, 32'h00010003, "no_write_in_reset_l2");
    push(4, 1, 32'h0, "cnt_after_reset");
    tick();
    set_a(1'b1, 4'hF, 32'h60, 32'h1);
    set_b(1'b1, 4'h0, 32'h60, 32'h0);
    push(4, 1, 32'd1, "cnt_restart_l1");
    push(5, 1, 32'd1, "cnt_restart_l2");
    tick();
    idle();
    repeat (4) tick();

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
